// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR and runs the instruction-memory
// request/ready handshake on behalf of the multicycle control FSM.
//
// state | meaning
// IDLE  | no fetch outstanding; load_ir starts one if PC is word-aligned
// REQ   | imem_req held high, waiting for imem_ready or timeout
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_ir,
    input  logic            load_pc,
    input  logic            pc_next_sel,
    input  logic            pc_adder_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ir,
    output logic [6:0]      opcode,
    output logic            ir_valid,
    output logic            busy,
    output logic            fetch_fault
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] NOP_INSN  = XLEN'(32'h0000_0013);
    localparam logic [7:0]      LAST_WAIT = 8'(TIMEOUT - 1);

    state_t          state;
    logic [7:0]      wait_cnt;
    logic [XLEN-1:0] pc_next;

    always_comb begin
        pc_next = pc + XLEN'(4);
        if (pc_next_sel) begin
            pc_next = {alu_result[XLEN-1:1], 1'b0};
        end else if (pc_adder_sel) begin
            pc_next = pc + imm;
        end
    end

    // imem_addr samples the pre-update PC, so fetch and PC advance can share an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ir          <= NOP_INSN;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            ir_valid    <= 1'b0;
            fetch_fault <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            ir_valid <= 1'b0;
            if (load_pc) begin
                pc <= pc_next;
            end
            case (state)
                IDLE: begin
                    if (load_ir) begin
                        if (pc[1:0] == 2'b00) begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            wait_cnt  <= '0;
                        end else begin
                            fetch_fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        state    <= IDLE;
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state       <= IDLE;
                        imem_req    <= 1'b0;
                        fetch_fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == REQ);
    assign opcode = ir[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written multi-cycle
// sequences and a randomized run, all checked against a transaction-level model.
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          TIMEOUT  = 15;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, load_ir, load_pc, pc_next_sel, pc_adder_sel, imem_ready;
    logic [31:0] imm, alu_result, imem_rdata;
    logic        imem_req, ir_valid, busy, fetch_fault;
    logic [31:0] imem_addr, pc, ir;
    logic [6:0]  opcode;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: a fetch is "outstanding" with a count of unanswered cycles
    logic [31:0] m_pc, m_ir, m_addr;
    logic        m_out, m_valid, m_fault;
    int          m_waited;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .load_ir(load_ir), .load_pc(load_pc),
        .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel), .imm(imm),
        .alu_result(alu_result), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .ir(ir),
        .opcode(opcode), .ir_valid(ir_valid), .busy(busy), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (reset) begin
            m_pc = RESET_PC; m_ir = NOP; m_addr = 0;
            m_out = 0; m_valid = 0; m_fault = 0; m_waited = 0;
            return;
        end
        m_valid = 0;
        if (!m_out) begin
            if (load_ir) begin
                if (old_pc % 4 == 0) begin
                    m_out = 1; m_waited = 0; m_addr = old_pc;
                end else begin
                    m_fault = 1;
                end
            end
        end else if (imem_ready) begin
            m_ir = imem_rdata; m_out = 0; m_valid = 1;
        end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
                m_out = 0; m_fault = 1;
            end
        end
        if (load_pc) begin
            if (pc_next_sel)       m_pc = alu_result & ~32'h1;
            else if (pc_adder_sel) m_pc = old_pc + imm;
            else                   m_pc = old_pc + 32'd4;
        end
    endtask

    task automatic model_compare();
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("opcode", {25'b0, opcode}, {25'b0, m_ir[6:0]});
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_out});
        chk("busy", {31'b0, busy}, {31'b0, m_out});
        chk("imem_addr", imem_addr, m_addr);
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_compare();
    endtask

    task automatic idle_inputs();
        reset = 0; load_ir = 0; load_pc = 0; pc_next_sel = 0; pc_adder_sel = 0;
        imm = 0; alu_result = 0; imem_ready = 0; imem_rdata = 0;
    endtask

    typedef struct {
        logic        rst, lir, lpc, nsel, asel, rdy;
        logic [31:0] imm_v, alu_v, rdata_v;
        logic [31:0] e_pc, e_ir, e_addr;
        logic        e_req, e_valid, e_fault;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int busy_cycles, valid_cnt;
        logic [31:0] held_addr, ir_before;

        //         rst lir lpc nsl asl rdy imm           alu           rdata         e_pc          e_ir          e_addr e_req e_v e_f
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          32'h0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          32'h0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        NOP,          32'h0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0050_0093,32'h4,        32'h0050_0093,32'h0, 0, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0050_0093,32'h0, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 1, 0, 0, 32'h0,        32'h203,      32'h0,        32'h202,      32'h0050_0093,32'h0, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h202,      32'h0050_0093,32'h0, 0, 0, 1};
        vecs[7]  = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          32'h0, 0, 0, 0};
        vecs[8]  = '{0, 0, 1, 1, 0, 0, 32'h0,        32'h100,      32'h0,        32'h100,      NOP,          32'h0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 0, 1, 0, 32'hFFFF_FFF8,32'h0,        32'h0,        32'hF8,       NOP,          32'h0, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 1, 0, 0, 32'h0,        32'hFFFF_FFFC,32'h0,        32'hFFFF_FFFC,NOP,          32'h0, 0, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          32'h0, 0, 0, 0};

        idle_inputs();
        reset = 1;
        for (int i = 0; i < 12; i++) begin
            reset = vecs[i].rst; load_ir = vecs[i].lir; load_pc = vecs[i].lpc;
            pc_next_sel = vecs[i].nsel; pc_adder_sel = vecs[i].asel; imem_ready = vecs[i].rdy;
            imm = vecs[i].imm_v; alu_result = vecs[i].alu_v; imem_rdata = vecs[i].rdata_v;
            step();
            chk($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d ir", i), ir, vecs[i].e_ir);
            chk($sformatf("vec%0d opcode", i), {25'b0, opcode}, {25'b0, vecs[i].e_ir[6:0]});
            chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("vec%0d valid", i), {31'b0, ir_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].e_fault});
        end

        // wait states: ready after 3 empty REQ cycles, stray load_ir mid-wait
        idle_inputs();
        reset = 1; step(); reset = 0;
        load_pc = 1; pc_next_sel = 1; alu_result = 32'h40; step();
        idle_inputs(); load_ir = 1; step();
        load_ir = 0;
        held_addr = 32'h40;
        valid_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            chk("wait req held", {31'b0, imem_req}, 32'h1);
            chk("wait addr held", imem_addr, held_addr);
            load_ir = (i == 1);
            imem_ready = (i == 3);
            imem_rdata = 32'h00A0_0113;
            step();
            valid_cnt += int'(ir_valid);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            valid_cnt += int'(ir_valid);
        end
        chk("wait ir_valid pulses", 32'(valid_cnt), 32'd1);
        chk("wait ir", ir, 32'h00A0_0113);
        chk("wait no refetch", {31'b0, imem_req}, 32'h0);

        // timeout with imem_ready never asserted
        ir_before = ir;
        load_ir = 1; step(); load_ir = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            step();
        end
        chk("timeout REQ cycles", 32'(busy_cycles), 32'(TIMEOUT));
        chk("timeout req dropped", {31'b0, imem_req}, 32'h0);
        chk("timeout fault", {31'b0, fetch_fault}, 32'h1);
        chk("timeout ir kept", ir, ir_before);
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; step();
        idle_inputs(); step();
        chk("late ready ignored", ir, ir_before);

        // reset during REQ, then a stale ready
        reset = 1; step(); reset = 0;
        load_ir = 1; step(); load_ir = 0;
        chk("pre-reset req", {31'b0, imem_req}, 32'h1);
        reset = 1; step(); reset = 0;
        chk("reset req", {31'b0, imem_req}, 32'h0);
        chk("reset pc", pc, RESET_PC);
        chk("reset fault", {31'b0, fetch_fault}, 32'h0);
        imem_ready = 1; imem_rdata = 32'hCAFE_F00D; step();
        chk("stale ready ir", ir, NOP);
        chk("stale ready valid", {31'b0, ir_valid}, 32'h0);

        // randomized traffic against the model
        idle_inputs();
        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(99) < 2);
            load_ir      = ($urandom_range(99) < 30);
            load_pc      = ($urandom_range(99) < 25);
            pc_next_sel  = ($urandom_range(99) < 30);
            pc_adder_sel = $urandom_range(1);
            imm          = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            alu_result   = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            imem_ready   = ($urandom_range(99) < 20);
            imem_rdata   = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
